collision_lives_ctrl: RTL and testbench
=======================================

Name: collision_lives_ctrl

Overview:
- Parametrised per-frame collision and damage manager for the game top.
- Replaces the fixed 7-segment detector and the constant player-lives register.
- Once per frame, scans a configurable number of dragon segments serially against the player, sword and sheep tiles.
- Maintains lives, invulnerability frames, saturating score and a sticky game-over state, consumed by the PPU heart entity and the APU.

Parameters:
- NUM_SEG, 7, number of dragon segments scanned (1..16).
- MAX_LIVES, 3, lives loaded at reset/restart.
- LIVES_W, 2, width of lives output; must hold MAX_LIVES.
- INVULN_FRAMES, 60, frames of invulnerability after a player hit (>=1).
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  single-cycle pulse at start of vertical blank; starts a scan
- restart  in  1  single-cycle pulse; new game
- player_pos  in  8  player tile xxxx_yyyy
- sword_pos  in  8  sword tile xxxx_yyyy
- sword_active  in  1  sword currently visible
- sheep_pos  in  8  sheep tile xxxx_yyyy
- seg_active  in  NUM_SEG  per-segment visible flag
- seg_pos  in  8*NUM_SEG  segment tiles; segment i at [8i+7:8i]; segment 0 = head
- busy  out  1  scan in progress
- hit_valid  out  1  one-cycle pulse: hit flags updated
- player_hit  out  1  player overlapped an active segment this frame
- sword_hit  out  1  active sword overlapped an active segment this frame
- sheep_hit  out  1  sheep overlapped an active segment this frame
- lives  out  LIVES_W  remaining lives
- invuln  out  1  invulnerability window active
- game_over  out  1  sticky; lives exhausted
- score  out  SCORE_W  saturating count of frames with sword_hit
- sword_hit_idx  out  4  lowest index of segment hit by sword (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM to IDLE; busy=0, hit_valid=0, all hit flags 0.
  - lives=MAX_LIVES; invuln counter 0 (invuln=0); game_over=0; score=0; sword_hit_idx=0.
- FSM states: IDLE, SCAN, UPDATE.
- IDLE:
  - frame_start=1 at edge t: snapshot player_pos, sword_pos, sword_active, sheep_pos, seg_active, seg_pos.
  - Clear scan accumulators; idx=0; go to SCAN; busy=1 from t+1.
- SCAN:
  - One segment per cycle: idx 0..NUM_SEG-1, compared against the snapshot only.
  - Hit on segment i = seg_active[i] && seg_pos_i == target; sword target also requires sword_active.
  - Accumulators OR-in hits.
  - After idx=NUM_SEG-1, go to UPDATE. SCAN occupies exactly NUM_SEG cycles.
- UPDATE: on exit (one cycle), in parallel:
  - Hit flags loaded from accumulators; hit_valid=1 for exactly one cycle; busy=0; return to IDLE.
  - Flags visible in cycle t+NUM_SEG+2 and held until the next hit_valid.
  - If invuln counter>0: decrement by 1.
  - Else if player_hit && lives>0 && !game_over: lives-1 and counter=INVULN_FRAMES.
  - A hit does not reload a nonzero counter.
  - If lives becomes 0: game_over=1.
  - If sword_hit && !game_over: score+1, saturating at all-ones.
  - At most one increment per frame regardless of segment count.
- invuln = (counter != 0).
- frame_start while busy: ignored; no queueing.
- restart (any state):
  - lives=MAX_LIVES, score=0, game_over=0, counter=0, hit flags 0.
  - Scan aborted to IDLE, no hit_valid.
- restart and frame_start in the same cycle: restart wins; no scan starts.
- While game_over: scans still run and flags still update; lives and score frozen.
- Position compare is exact 8-bit equality; no wrap-around arithmetic.

Optional Feature:
- Macro: COLLISION_HIT_INDEX_EN.
- Defined: sword_hit_idx loads, at UPDATE, the lowest segment index whose sword compare hit this frame. It is 0 if no hit and holds its value between frames.
- Undefined: sword_hit_idx is tied to 0 and the index-capture logic is absent.

Decomposition:
- Shared package game_pkg: tile position width (8), x/y field slices, FSM state encoding (IDLE/SCAN/UPDATE), sprite/orientation constants already used by the PPU.
- One sub-module, tile_match: combinational active && equality compare for one target. Instantiated three times (player, sword, sheep) on the currently indexed segment.

Test Plan:
- Reset, then frame_start with no overlaps, NUM_SEG=7 -> hit_valid pulses 9 cycles after frame_start; all flags 0; lives=3; score=0.
- player_pos=8'h45, seg 3 active at 8'h45 -> player_hit=1; lives 3->2; invuln=1 for the next 60 UPDATEs; repeated overlap during that window leaves lives=2.
- Sword active at 8'h22 hitting segments 2 and 5 -> sword_hit=1; score+1 (once); sword_hit_idx=2 with COLLISION_HIT_INDEX_EN; sword_active=0 at the same position -> no hit.
- Three spaced player hits (invuln expired each time) -> lives 0, game_over=1; further sword hits leave score unchanged; restart -> lives=3, score=0, game_over=0.
- frame_start issued 3 cycles into a scan -> ignored, single hit_valid; restart at scan cycle 4 -> busy=0 next cycle, no hit_valid.
- score preloaded to 8'hFF by 255 sword frames -> a further sword hit keeps score=8'hFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: tile position layout, collision FSM state
// encoding and sprite constants also used by the PPU.
package game_pkg;

    localparam int TILE_W = 8;  // xxxx_yyyy
    localparam int TILE_X_MSB = 7;
    localparam int TILE_X_LSB = 4;
    localparam int TILE_Y_MSB = 3;
    localparam int TILE_Y_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_UPDATE = 2'd2
    } coll_state_t;

    typedef enum logic [1:0] {
        ORIENT_UP    = 2'd0,
        ORIENT_RIGHT = 2'd1,
        ORIENT_DOWN  = 2'd2,
        ORIENT_LEFT  = 2'd3
    } orient_t;

    localparam logic [3:0] SPR_HEART = 4'd9;

    function automatic logic [3:0] tile_x(input logic [TILE_W-1:0] pos);
        return pos[TILE_X_MSB:TILE_X_LSB];
    endfunction

    function automatic logic [3:0] tile_y(input logic [TILE_W-1:0] pos);
        return pos[TILE_Y_MSB:TILE_Y_LSB];
    endfunction

endpackage

// File: rtl/tile_match.sv
// Combinational tile compare: hit when the segment is enabled and its tile
// equals the target tile exactly (no wrap-around).
module tile_match
    import game_pkg::*;
(
    input  logic              en_i,
    input  logic [TILE_W-1:0] seg_pos_i,
    input  logic [TILE_W-1:0] target_i,
    output logic              hit_o
);

    assign hit_o = en_i && (seg_pos_i == target_i);

endmodule

// File: rtl/collision_lives_ctrl.sv
// Per-frame collision and damage manager. On frame_start the inputs are
// snapshotted and the dragon segments are scanned one per cycle against the
// player, sword and sheep tiles; the result then updates lives,
// invulnerability, score and game-over in a single UPDATE cycle.
// Optional build macro COLLISION_HIT_INDEX_EN: capture the lowest segment
// index hit by the sword on sword_hit_idx (tied to 0 when undefined).
module collision_lives_ctrl
    import game_pkg::*;
#(
    parameter int NUM_SEG       = 7,
    parameter int MAX_LIVES     = 3,
    parameter int LIVES_W       = 2,
    parameter int INVULN_FRAMES = 60,
    parameter int SCORE_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      restart,
    input  logic [TILE_W-1:0]         player_pos,
    input  logic [TILE_W-1:0]         sword_pos,
    input  logic                      sword_active,
    input  logic [TILE_W-1:0]         sheep_pos,
    input  logic [NUM_SEG-1:0]        seg_active,
    input  logic [TILE_W*NUM_SEG-1:0] seg_pos,
    output logic                      busy,
    output logic                      hit_valid,
    output logic                      player_hit,
    output logic                      sword_hit,
    output logic                      sheep_hit,
    output logic [LIVES_W-1:0]        lives,
    output logic                      invuln,
    output logic                      game_over,
    output logic [SCORE_W-1:0]        score,
    output logic [3:0]                sword_hit_idx
);

    localparam int         INV_W    = $clog2(INVULN_FRAMES + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_SEG - 1);

    coll_state_t               state_q;
    logic [3:0]                idx_q;
    logic                      acc_player_q, acc_sword_q, acc_sheep_q;
    logic [INV_W-1:0]          inv_cnt_q;

    logic [TILE_W-1:0]         player_q, sword_q, sheep_q;
    logic                      sword_act_q;
    logic [NUM_SEG-1:0]        seg_active_q;
    logic [TILE_W*NUM_SEG-1:0] seg_pos_q;

    logic [TILE_W-1:0]         cur_pos;
    logic                      cur_act;
    logic                      m_player, m_sword, m_sheep;
    logic                      start_scan;

    assign start_scan = (state_q == ST_IDLE) && frame_start && !restart;
    assign invuln     = (inv_cnt_q != '0);

    // Input snapshot taken when a scan starts; the scan never looks at live inputs.
    always_ff @(posedge clk) begin
        if (start_scan) begin
            player_q     <= player_pos;
            sword_q      <= sword_pos;
            sword_act_q  <= sword_active;
            sheep_q      <= sheep_pos;
            seg_active_q <= seg_active;
            seg_pos_q    <= seg_pos;
        end
    end

    // Select the snapshot segment addressed by the scan index.
    always_comb begin
        cur_pos = '0;
        cur_act = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (idx_q == 4'(i)) begin
                cur_pos = seg_pos_q[TILE_W*i +: TILE_W];
                cur_act = seg_active_q[i];
            end
        end
    end

    tile_match u_match_player (.en_i(cur_act),               .seg_pos_i(cur_pos), .target_i(player_q), .hit_o(m_player));
    tile_match u_match_sword  (.en_i(cur_act && sword_act_q), .seg_pos_i(cur_pos), .target_i(sword_q),  .hit_o(m_sword));
    tile_match u_match_sheep  (.en_i(cur_act),               .seg_pos_i(cur_pos), .target_i(sheep_q),  .hit_o(m_sheep));

    // Scan FSM plus lives / invulnerability / score / game-over bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
            hit_valid    <= 1'b0;
            player_hit   <= 1'b0;
            sword_hit    <= 1'b0;
            sheep_hit    <= 1'b0;
            lives        <= LIVES_W'(MAX_LIVES);
            inv_cnt_q    <= '0;
            game_over    <= 1'b0;
            score        <= '0;
            idx_q        <= '0;
            acc_player_q <= 1'b0;
            acc_sword_q  <= 1'b0;
            acc_sheep_q  <= 1'b0;
        end else if (restart) begin
            state_q    <= ST_IDLE;
            busy       <= 1'b0;
            hit_valid  <= 1'b0;
            player_hit <= 1'b0;
            sword_hit  <= 1'b0;
            sheep_hit  <= 1'b0;
            lives      <= LIVES_W'(MAX_LIVES);
            inv_cnt_q  <= '0;
            game_over  <= 1'b0;
            score      <= '0;
        end else begin
            hit_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q      <= ST_SCAN;
                        busy         <= 1'b1;
                        idx_q        <= '0;
                        acc_player_q <= 1'b0;
                        acc_sword_q  <= 1'b0;
                        acc_sheep_q  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    acc_player_q <= acc_player_q | m_player;
                    acc_sword_q  <= acc_sword_q  | m_sword;
                    acc_sheep_q  <= acc_sheep_q  | m_sheep;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_UPDATE: begin
                    state_q    <= ST_IDLE;
                    busy       <= 1'b0;
                    hit_valid  <= 1'b1;
                    player_hit <= acc_player_q;
                    sword_hit  <= acc_sword_q;
                    sheep_hit  <= acc_sheep_q;
                    // A running window only counts down; hits never re-arm it.
                    if (inv_cnt_q != '0) begin
                        inv_cnt_q <= inv_cnt_q - 1'b1;
                    end else if (acc_player_q && (lives != '0) && !game_over) begin
                        lives     <= lives - 1'b1;
                        inv_cnt_q <= INV_W'(INVULN_FRAMES);
                        if (lives == LIVES_W'(1)) begin
                            game_over <= 1'b1;
                        end
                    end
                    if (acc_sword_q && !game_over && (score != '1)) begin
                        score <= score + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef COLLISION_HIT_INDEX_EN
    logic [3:0] first_idx_q;
    logic [3:0] hit_idx_q;

    // Remember the first (lowest) segment the sword hit; publish it at UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_idx_q <= '0;
            hit_idx_q   <= '0;
        end else if (!restart) begin
            if (start_scan) begin
                first_idx_q <= '0;
            end else if (state_q == ST_SCAN && m_sword && !acc_sword_q) begin
                first_idx_q <= idx_q;
            end else if (state_q == ST_UPDATE) begin
                hit_idx_q <= first_idx_q;
            end
        end
    end

    assign sword_hit_idx = hit_idx_q;
`else
    assign sword_hit_idx = 4'd0;
`endif

endmodule

// File: tb/tb_collision_lives_ctrl.sv
// Randomised self-checking bench for collision_lives_ctrl with a frame-level
// reference model (hits from array scans, lives/score from the game rules).
module tb_collision_lives_ctrl;

    localparam int NUM_SEG   = 7;
    localparam int MAX_LIVES = 3;
    localparam int LIVES_W   = 2;
    localparam int INV       = 60;
    localparam int SCORE_W   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, frame_start, restart;
    logic [7:0]           player_pos, sword_pos, sheep_pos;
    logic                 sword_active;
    logic [NUM_SEG-1:0]   seg_active;
    logic [8*NUM_SEG-1:0] seg_pos;
    logic                 busy, hit_valid, player_hit, sword_hit, sheep_hit;
    logic [LIVES_W-1:0]   lives;
    logic                 invuln, game_over;
    logic [SCORE_W-1:0]   score;
    logic [3:0]           sword_hit_idx;

    logic [7:0] spos [NUM_SEG];
    for (genvar g = 0; g < NUM_SEG; g++) begin : g_pack
        assign seg_pos[8*g +: 8] = spos[g];
    end

    collision_lives_ctrl #(
        .NUM_SEG(NUM_SEG), .MAX_LIVES(MAX_LIVES), .LIVES_W(LIVES_W),
        .INVULN_FRAMES(INV), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .restart(restart),
        .player_pos(player_pos), .sword_pos(sword_pos), .sword_active(sword_active),
        .sheep_pos(sheep_pos), .seg_active(seg_active), .seg_pos(seg_pos),
        .busy(busy), .hit_valid(hit_valid), .player_hit(player_hit),
        .sword_hit(sword_hit), .sheep_hit(sheep_hit), .lives(lives),
        .invuln(invuln), .game_over(game_over), .score(score),
        .sword_hit_idx(sword_hit_idx)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int m_lives, m_cnt, m_score, m_idx;
    bit m_go, m_ph, m_sh, m_shp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".lives"},  32'(lives),         32'(m_lives));
        chk({tag, ".invuln"}, 32'(invuln),        32'(m_cnt != 0));
        chk({tag, ".gover"},  32'(game_over),     32'(m_go));
        chk({tag, ".score"},  32'(score),         32'(m_score));
        chk({tag, ".php"},    32'(player_hit),    32'(m_ph));
        chk({tag, ".swh"},    32'(sword_hit),     32'(m_sh));
        chk({tag, ".shh"},    32'(sheep_hit),     32'(m_shp));
        chk({tag, ".idx"},    32'(sword_hit_idx), 32'(m_idx));
    endtask

    task automatic model_restart();
        m_lives = MAX_LIVES; m_cnt = 0; m_score = 0; m_go = 0;
        m_ph = 0; m_sh = 0; m_shp = 0;
    endtask

    task automatic clear_scene();
        player_pos = 8'hF0; sword_pos = 8'hF1; sheep_pos = 8'hF2; sword_active = 1'b1;
        for (int i = 0; i < NUM_SEG; i++) spos[i] = 8'h10 + 8'(i);
        seg_active = '1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_restart();
    endtask

    // Runs one full frame; optionally pokes frame_start mid-scan (must be ignored).
    task automatic run_frame(input string tag, input bit inject);
        bit ph = 0, sh = 0, shp = 0, found = 0, go0;
        int first = 0, n = 0, extra = 0;
        logic [7:0] sv_p, sv_s, sv_sh;
        logic [7:0] sv_pos [NUM_SEG];
        logic [NUM_SEG-1:0] sv_act;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (seg_active[i] && spos[i] == player_pos) ph = 1;
            if (seg_active[i] && sword_active && spos[i] == sword_pos) begin
                if (!found) first = i;
                found = 1; sh = 1;
            end
            if (seg_active[i] && spos[i] == sheep_pos) shp = 1;
        end
        sv_p = player_pos; sv_s = sword_pos; sv_sh = sheep_pos; sv_act = seg_active;
        for (int i = 0; i < NUM_SEG; i++) sv_pos[i] = spos[i];

        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        // scramble live inputs: the scan must use its snapshot
        player_pos = ~sv_p; sword_pos = ~sv_s; sheep_pos = ~sv_sh; seg_active = ~sv_act;
        for (int i = 0; i < NUM_SEG; i++) spos[i] = 8'($urandom);
        chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
        while (n < 40 && !hit_valid) begin
            frame_start = (inject && n == 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        frame_start = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(NUM_SEG + 1));
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);

        go0 = m_go;
        m_ph = ph; m_sh = sh; m_shp = shp;
        if (m_cnt > 0) m_cnt--;
        else if (ph && m_lives > 0 && !m_go) begin
            m_lives--; m_cnt = INV;
            if (m_lives == 0) m_go = 1;
        end
        if (sh && !go0 && m_score < 255) m_score++;
`ifdef COLLISION_HIT_INDEX_EN
        m_idx = sh ? first : 0;
`else
        m_idx = 0;
`endif
        check_state(tag);

        player_pos = sv_p; sword_pos = sv_s; sheep_pos = sv_sh; seg_active = sv_act;
        for (int i = 0; i < NUM_SEG; i++) spos[i] = sv_pos[i];
        @(posedge clk); #1;
        chk({tag, ".hv_pulse"}, 32'(hit_valid), 32'd0);
        if (inject) begin
            for (int k = 0; k < 14; k++) begin
                if (hit_valid) extra++;
                @(posedge clk); #1;
            end
            chk({tag, ".no_queue"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] pool [4];
        int hv_cnt;
        pool[0] = 8'h11; pool[1] = 8'h22; pool[2] = 8'h33; pool[3] = 8'h45;
        rst_n = 1'b0; frame_start = 1'b0; restart = 1'b0;
        clear_scene();
        m_idx = 0;
        model_restart();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.hv", 32'(hit_valid), 32'd0);
        check_state("reset");

        // no overlaps
        run_frame("clean", 0);

        // player hit then invulnerability window with continued overlap
        player_pos = 8'h45; spos[3] = 8'h45;
        run_frame("phit", 0);
        chk("phit.lives2", 32'(lives), 32'd2);
        for (int f = 0; f < INV; f++) run_frame("inv", 0);
        chk("inv.lives2", 32'(lives), 32'd2);

        // sword hits on segments 2 and 5, then sword inactive
        clear_scene();
        sword_pos = 8'h22; spos[2] = 8'h22; spos[5] = 8'h22;
        run_frame("sword", 0);
        sword_active = 1'b0;
        run_frame("sword_off", 0);

        // play into game over, then sword hits must not score
        do_restart();
        check_state("rst1");
        clear_scene();
        player_pos = 8'h45; spos[3] = 8'h45;
        for (int f = 0; f < 250 && !m_go; f++) begin
            if (m_cnt == 0) spos[3] = 8'h45; else spos[3] = 8'h13;
            run_frame("gover", 0);
        end
        chk("gover.flag", 32'(game_over), 32'd1);
        clear_scene();
        sword_pos = 8'h22; spos[2] = 8'h22;
        run_frame("gover_sw", 0);
        run_frame("gover_sw", 0);
        do_restart();
        check_state("rst2");

        // frame_start mid-scan ignored
        run_frame("inject", 1);

        // restart on scan cycle 4 aborts without hit_valid
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_restart();
        chk("abort.busy", 32'(busy), 32'd0);
        hv_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (hit_valid) hv_cnt++;
            @(posedge clk); #1;
        end
        chk("abort.no_hv", 32'(hv_cnt), 32'd0);
        check_state("abort");

        // restart and frame_start together: no scan
        restart = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; frame_start = 1'b0;
        model_restart();
        chk("rs_fs.busy", 32'(busy), 32'd0);
        hv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (hit_valid) hv_cnt++;
            @(posedge clk); #1;
        end
        chk("rs_fs.no_hv", 32'(hv_cnt), 32'd0);

        // score saturation
        for (int f = 0; f < 256; f++) run_frame("sat", 0);
        chk("sat.ff", 32'(score), 32'hFF);

        // randomised frames
        do_restart();
        for (int f = 0; f < 80; f++) begin
            player_pos   = pool[$urandom_range(0, 3)];
            sword_pos    = pool[$urandom_range(0, 3)];
            sheep_pos    = pool[$urandom_range(0, 3)];
            sword_active = 1'($urandom);
            seg_active   = NUM_SEG'($urandom);
            for (int i = 0; i < NUM_SEG; i++) spos[i] = ($urandom_range(0, 2) == 0) ? 8'h77 : pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0) begin
                do_restart();
                check_state("rnd_rst");
            end
            run_frame("rnd", 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
